sha256crypt_cmp_config_tx: RTL and testbench

//  Serializes a CMP_CONFIG packet into the byte stream accepted by the cmp_config parser:
//  0x00, salt_len, 16 salt bytes, 4 iter_cnt bytes, 2 hash_count bytes, 4*hash_count

---
 rtl/sha256crypt_cmp_config_tx_if.sv | 32 +++
 rtl/sha256crypt_cmp_config_tx.sv | 188 ++++++++++++++++++
 tb/tb_sha256crypt_cmp_config_tx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha256crypt_cmp_config_tx_if.sv
// Bundle between the test/control logic and the CMP_CONFIG serializer.
// Carries the parallel config, the hash RAM read port, the byte stream and the status flags.
interface sha256crypt_cmp_config_tx_if #(
    parameter int unsigned HASH_COUNT_W = 11,
    parameter int unsigned HASH_ADDR_W  = 10
);
    logic                    start;
    logic                    mode_cmp;
    logic [4:0]              salt_len;
    logic [127:0]            salt;
    logic [31:0]             iter_cnt;
    logic [HASH_COUNT_W-1:0] hash_count;
    logic                    hash_rd_en;
    logic [HASH_ADDR_W-1:0]  hash_rd_addr;
    logic [31:0]             hash_rd_data;
    logic [7:0]              dout;
    logic                    wr_en;
    logic                    full;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, mode_cmp, salt_len, salt, iter_cnt, hash_count, hash_rd_data, full,
        input  hash_rd_en, hash_rd_addr, dout, wr_en, busy, done, err
    );

    modport slave (
        input  start, mode_cmp, salt_len, salt, iter_cnt, hash_count, hash_rd_data, full,
        output hash_rd_en, hash_rd_addr, dout, wr_en, busy, done, err
    );
endinterface

// File: rtl/sha256crypt_cmp_config_tx.sv
// Serializes a latched CMP_CONFIG into the byte stream of the cmp_config parser,
// prefetching comparator words from the hash RAM so the stream has no bubbles.
module sha256crypt_cmp_config_tx #(
    parameter int unsigned HASH_COUNT_W = 11,
    parameter int unsigned HASH_ADDR_W  = 10
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    sha256crypt_cmp_config_tx_if.slave tx_io
);
    typedef enum logic [3:0] {
        StIdle, StHdr, StSaltLen, StSalt, StIter, StHc0, StHc1, StCmp, StMagic, StError
    } state_e;

    state_e                 state_q;
    logic [127:0]           salt_q;
    logic [4:0]             salt_len_q;
    logic [31:0]            iter_q;
    logic [15:0]            cnt_q;
    logic [3:0]             idx_q;
    logic [15:0]            widx_q;
    logic [23:0]            sh_q;
    logic [31:0]            hold_q;
    logic                   hold_vld_q;
    logic                   rd_pend_q;
    logic [7:0]             dout_q;
    logic                   wr_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic                   rd_en_q;
    logic [HASH_ADDR_W-1:0] rd_addr_q;

    logic [HASH_COUNT_W-1:0] hc_eff;
    logic                    cfg_bad;
    logic                    accept;
    logic [31:0]             word;
    logic [3:0]              idx_nx;
    logic [16:0]             load_idx;
    logic                    more_words;

    assign hc_eff  = tx_io.mode_cmp ? tx_io.hash_count : '0;
    assign cfg_bad = (tx_io.salt_len == 5'd0) || (tx_io.salt_len > 5'd16);
    assign accept  = wr_en_q & ~tx_io.full;
    // RAM data is live the cycle after the read strobe; later it sits in hold_q.
    assign word    = hold_vld_q ? hold_q : tx_io.hash_rd_data;
    assign idx_nx  = idx_q + 4'd1;
    // Index of the word entering the shift register; its successor is prefetched if it exists.
    assign load_idx   = (state_q == StHc1) ? 17'd0 : {1'b0, widx_q} + 17'd1;
    assign more_words = (load_idx + 17'd1) < {1'b0, cnt_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            salt_q     <= '0;
            salt_len_q <= '0;
            iter_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            widx_q     <= '0;
            sh_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_pend_q <= rd_en_q;
            if (rd_pend_q) begin
                hold_q     <= tx_io.hash_rd_data;
                hold_vld_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tx_io.start) begin
                        salt_q     <= tx_io.salt;
                        salt_len_q <= tx_io.salt_len;
                        iter_q     <= tx_io.iter_cnt;
                        cnt_q      <= 16'(hc_eff);
                        if (cfg_bad) begin
                            err_q   <= 1'b1;
                            state_q <= StError;
                        end else begin
                            dout_q  <= 8'h00;
                            wr_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= StHdr;
                        end
                    end
                end
                StHdr: begin
                    if (accept) begin
                        dout_q  <= {3'b000, salt_len_q};
                        state_q <= StSaltLen;
                    end
                end
                StSaltLen: begin
                    if (accept) begin
                        dout_q  <= salt_q[7:0];
                        idx_q   <= 4'd0;
                        state_q <= StSalt;
                    end
                end
                StSalt: begin
                    if (accept) begin
                        if (idx_q == 4'd15) begin
                            dout_q  <= iter_q[7:0];
                            idx_q   <= 4'd0;
                            state_q <= StIter;
                        end else begin
                            dout_q <= salt_q[{idx_nx, 3'b000} +: 8];
                            idx_q  <= idx_nx;
                        end
                    end
                end
                StIter: begin
                    if (accept) begin
                        if (idx_q == 4'd3) begin
                            dout_q  <= cnt_q[7:0];
                            state_q <= StHc0;
                            if (cnt_q != 16'd0) begin
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= '0;
                            end
                        end else begin
                            dout_q <= iter_q[{idx_nx[1:0], 3'b000} +: 8];
                            idx_q  <= idx_nx;
                        end
                    end
                end
                StHc0: begin
                    if (accept) begin
                        dout_q  <= cnt_q[15:8];
                        state_q <= StHc1;
                    end
                end
                StHc1, StCmp: begin
                    if (accept) begin
                        if (state_q == StCmp && idx_q[1:0] != 2'd3) begin
                            dout_q <= sh_q[7:0];
                            sh_q   <= {8'h00, sh_q[23:8]};
                            idx_q  <= idx_nx;
                        end else if (load_idx == {1'b0, cnt_q}) begin
                            dout_q  <= 8'hCC;
                            state_q <= StMagic;
                        end else begin
                            dout_q     <= word[7:0];
                            sh_q       <= word[31:8];
                            widx_q     <= load_idx[15:0];
                            idx_q      <= 4'd0;
                            hold_vld_q <= 1'b0;
                            state_q    <= StCmp;
                            if (more_words) begin
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= rd_addr_q + HASH_ADDR_W'(1);
                            end
                        end
                    end
                end
                StMagic: begin
                    if (accept) begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StError: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_io.dout         = dout_q;
    assign tx_io.wr_en        = wr_en_q;
    assign tx_io.busy         = busy_q;
    assign tx_io.done         = done_q;
    assign tx_io.err          = err_q;
    assign tx_io.hash_rd_en   = rd_en_q;
    assign tx_io.hash_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_sha256crypt_cmp_config_tx.sv
// Bench for the CMP_CONFIG serializer: directed and randomized packets against a byte-list
// model, with random backpressure, config errors and a mid-packet reset.
module tb_sha256crypt_cmp_config_tx;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    sha256crypt_cmp_config_tx_if #(.HASH_COUNT_W(11), .HASH_ADDR_W(10)) tb_if ();

    sha256crypt_cmp_config_tx #(
        .HASH_COUNT_W(11),
        .HASH_ADDR_W (10)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .tx_io (tb_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ram [0:1023];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          exp_reads;
    int          edge_n = 0, rd_cnt = 0, rd_base = 0, addr_bad = 0, stall_bad = 0;
    int          done_cnt = 0, done_edge = 0, wr_cnt = 0;
    bit          rand_full = 1'b0;
    bit          rnd_bit = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [7:0]  prev_dout = 8'h00;

    assign tb_if.full = rand_full & rnd_bit;

    always @(posedge clk_i) begin
        edge_n <= edge_n + 1;
        if (tb_if.hash_rd_en) tb_if.hash_rd_data <= ram[tb_if.hash_rd_addr];
    end

    always @(posedge clk_i) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clk_i) begin
        if (tb_if.wr_en && !tb_if.full) got_q.push_back(tb_if.dout);
        if (tb_if.wr_en) wr_cnt <= wr_cnt + 1;
        if (stalled_prev && (!tb_if.wr_en || tb_if.dout !== prev_dout)) stall_bad <= stall_bad + 1;
        stalled_prev <= tb_if.wr_en & tb_if.full;
        prev_dout    <= tb_if.dout;
        if (tb_if.hash_rd_en) begin
            if (int'(tb_if.hash_rd_addr) != ((rd_cnt - rd_base) % 1024)) addr_bad <= addr_bad + 1;
            rd_cnt <= rd_cnt + 1;
        end
        if (tb_if.done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= edge_n;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packet as the parser expects it, built straight from the field list.
    function automatic void build_exp(input int sl, input logic [127:0] s, input logic [31:0] it,
                                      input bit mode, input int hc);
        int          eff;
        logic [31:0] w;
        eff = mode ? hc : 0;
        exp_reads = eff;
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(sl));
        for (int i = 0; i < 16; i++) exp_q.push_back(s[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(it[8*i +: 8]);
        exp_q.push_back(8'(eff % 256));
        exp_q.push_back(8'(eff / 256));
        for (int k = 0; k < eff; k++) begin
            w = ram[k % 1024];
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
        exp_q.push_back(8'hCC);
    endfunction

    task automatic apply_cfg(input int sl, input logic [127:0] s, input logic [31:0] it,
                             input bit mode, input int hc);
        tb_if.salt_len   = 5'(sl);
        tb_if.salt       = s;
        tb_if.iter_cnt   = it;
        tb_if.mode_cmp   = mode;
        tb_if.hash_count = 11'(hc);
    endtask

    task automatic pulse_start();
        @(posedge clk_i);
        #1 tb_if.start = 1'b1;
        @(posedge clk_i);
        #1 tb_if.start = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input int sl, input logic [127:0] s,
                           input logic [31:0] it, input bit mode, input int hc, input bit stall);
        int e0, sb0, db0, ab0, n;
        logic [7:0] g;
        build_exp(sl, s, it, mode, hc);
        rand_full = stall;
        repeat (2) @(posedge clk_i);
        #1;
        got_q.delete();
        rd_base = rd_cnt;
        sb0 = stall_bad;
        db0 = done_cnt;
        ab0 = addr_bad;
        apply_cfg(sl, s, it, mode, hc);
        tb_if.start = 1'b1;
        @(posedge clk_i);
        #1 tb_if.start = 1'b0;
        e0 = edge_n;
        chk({tag, " first_byte"}, {tb_if.busy, tb_if.wr_en, tb_if.dout}, {2'b11, 8'h00});
        n = 0;
        while (done_cnt == db0 && n < 20000) begin
            @(posedge clk_i);
            #1 n++;
        end
        chk({tag, " done_pulses"}, done_cnt - db0, 1);
        chk({tag, " length"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            chk($sformatf("%s byte%0d", tag, i), g, exp_q[i]);
            if (g !== exp_q[i]) break;
        end
        chk({tag, " ram_reads"}, rd_cnt - rd_base, exp_reads);
        chk({tag, " ram_addr_seq"}, addr_bad - ab0, 0);
        chk({tag, " stall_hold"}, stall_bad - sb0, 0);
        if (!stall) chk({tag, " done_latency"}, done_edge - e0, exp_q.size());
        chk({tag, " busy_after"}, tb_if.busy, 1'b0);
        rand_full = 1'b0;
    endtask

    initial begin
        logic [127:0] s;
        int           wb, n;
        tb_if.start        = 1'b0;
        apply_cfg(8, '0, 32'd0, 1'b0, 0);
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst dout", tb_if.dout, 8'h00);
        chk("rst wr_en", tb_if.wr_en, 1'b0);
        chk("rst busy", tb_if.busy, 1'b0);
        chk("rst done", tb_if.done, 1'b0);
        chk("rst err", tb_if.err, 1'b0);
        chk("rst rd_en", tb_if.hash_rd_en, 1'b0);
        chk("rst rd_addr", tb_if.hash_rd_addr, 10'd0);
        rst_ni = 1'b1;

        s = '0;
        for (int i = 0; i < 8; i++) s[8*i +: 8] = 8'h61 + 8'(i);
        run_pkt("abc_mode0", 8, s, 32'd5000, 1'b0, 0, 1'b0);
        chk("abc iter_lsb", exp_q[18], 8'h88);
        ram[0] = 32'h11223344;
        ram[1] = 32'hAABBCCDD;
        run_pkt("cmp2", 8, s, 32'd5000, 1'b1, 2, 1'b0);
        run_pkt("cmp2_stall", 8, s, 32'd5000, 1'b1, 2, 1'b1);
        run_pkt("mode0_hc300", 8, s, 32'd5000, 1'b0, 300, 1'b0);
        run_pkt("hc260", 16, {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 260, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) ram[i] = $urandom;
            run_pkt($sformatf("rnd%0d", t), $urandom_range(1, 16),
                    {$urandom, $urandom, $urandom, $urandom}, $urandom,
                    1'($urandom_range(0, 1)), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
        end

        // Rejected configurations.
        wb = wr_cnt;
        apply_cfg(0, s, 32'd1, 1'b1, 2);
        pulse_start();
        chk("len0 err", tb_if.err, 1'b1);
        chk("len0 busy", tb_if.busy, 1'b0);
        apply_cfg(8, s, 32'd1, 1'b1, 2);
        pulse_start();
        repeat (40) @(posedge clk_i);
        #1;
        chk("err start_ignored", wr_cnt - wb, 0);
        chk("err sticky", tb_if.err, 1'b1);
        rst_ni = 1'b0;
        #1 chk("err cleared", tb_if.err, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        wb = wr_cnt;
        apply_cfg(17, s, 32'd1, 1'b0, 0);
        pulse_start();
        chk("len17 err", tb_if.err, 1'b1);
        repeat (10) @(posedge clk_i);
        #1 chk("len17 no_bytes", wr_cnt - wb, 0);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset during the comparator bytes.
        got_q.delete();
        apply_cfg(16, {$urandom, $urandom, $urandom, $urandom}, 32'd7, 1'b1, 4);
        pulse_start();
        n = 0;
        while (got_q.size() < 29 && n < 200) begin
            @(negedge clk_i);
            #1 n++;
        end
        chk("midrst reached_cmp", got_q.size(), 29);
        rst_ni = 1'b0;
        #1;
        chk("midrst wr_en", tb_if.wr_en, 1'b0);
        chk("midrst busy", tb_if.busy, 1'b0);
        wb = got_q.size();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #1 chk("midrst silent", got_q.size(), wb);
        run_pkt("after_rst", 5, {$urandom, $urandom, $urandom, $urandom}, 32'd99, 1'b1, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
